// File: rtl/vdma_buff_scheduler.sv
// Frame-buffer ring scheduler for a VDMA: pre-loads buffer addresses, then for every
// completed frame reports its size/address and pushes the next free buffer address.
module vdma_buff_scheduler #(
    parameter int g_NUM_BUFF = 4,
    parameter int g_PRELOAD  = 2
) (
    input  logic        aclk_i,
    input  logic        aclk_rstn_i,
    input  logic        enable_i,
    input  logic [31:0] base_addr_i,
    input  logic [31:0] stride_i,
    input  logic        hold_valid_i,
    input  logic [2:0]  hold_idx_i,
    input  logic        buff_addr_fifo_full_i,
    output logic        buff_addr_fifo_wr_o,
    output logic [31:0] buff_addr_fifo_data_o,
    input  logic        frame_size_fifo_empty_i,
    output logic        frame_size_fifo_rd_o,
    input  logic [31:0] frame_size_i,
    output logic        frame_done_o,
    output logic [31:0] last_addr_o,
    output logic [31:0] last_size_o,
    output logic [2:0]  last_idx_o,
    output logic [15:0] frame_count_o,
    output logic        err_o
);

    typedef enum logic [2:0] {IDLE, PRIME, RUN, RDWAIT, PUSH} state_t;

    state_t      r_state;
    logic [2:0]  r_wr_idx;
    logic [2:0]  r_cmp_idx;
    logic [3:0]  r_outstanding;
    logic [3:0]  r_preload_cnt;
    logic        r_rd_phase;
    logic [31:0] r_base;
    logic [31:0] r_stride;

    function automatic logic [2:0] f_next_idx(input logic [2:0] idx);
        return (idx == 3'(g_NUM_BUFF - 1)) ? 3'd0 : idx + 3'd1;
    endfunction

    function automatic logic [31:0] f_addr(input logic [31:0] base, input logic [31:0] stride,
                                           input logic [2:0] idx);
        return base + stride * {29'd0, idx};
    endfunction

    // The reader's locked buffer is skipped once; the buffer after it is pushed instead.
    logic       w_skip;
    logic [2:0] w_push_idx;
    logic       w_out_sat;

    assign w_skip     = hold_valid_i && (hold_idx_i == r_wr_idx);
    assign w_push_idx = w_skip ? f_next_idx(r_wr_idx) : r_wr_idx;
    assign w_out_sat  = (r_outstanding >= 4'(g_NUM_BUFF));

    // NOTE: outputs live in the async-reset branch so a reset kills an in-flight write
    // immediately, without waiting for a clock edge.
    always_ff @(posedge aclk_i or negedge aclk_rstn_i) begin
        if (!aclk_rstn_i) begin
            r_state               <= IDLE;
            r_wr_idx              <= '0;
            r_cmp_idx             <= '0;
            r_outstanding         <= '0;
            r_preload_cnt         <= '0;
            r_rd_phase            <= 1'b0;
            r_base                <= '0;
            r_stride              <= '0;
            buff_addr_fifo_wr_o   <= 1'b0;
            buff_addr_fifo_data_o <= '0;
            frame_size_fifo_rd_o  <= 1'b0;
            frame_done_o          <= 1'b0;
            last_addr_o           <= '0;
            last_size_o           <= '0;
            last_idx_o            <= '0;
            frame_count_o         <= '0;
            err_o                 <= 1'b0;
        end else begin
            // NOTE: strobes default low here so every assertion below is a one-cycle pulse.
            buff_addr_fifo_wr_o  <= 1'b0;
            frame_size_fifo_rd_o <= 1'b0;
            frame_done_o         <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (enable_i) begin
                        r_state       <= PRIME;
                        r_wr_idx      <= '0;
                        r_cmp_idx     <= '0;
                        r_outstanding <= '0;
                        r_preload_cnt <= '0;
                        r_base        <= base_addr_i;
                        r_stride      <= stride_i;
                        err_o         <= 1'b0;
                    end
                end

                PRIME: begin
                    if (!enable_i) begin
                        r_state <= IDLE;
                    end else if (!buff_addr_fifo_full_i) begin
                        buff_addr_fifo_wr_o   <= 1'b1;
                        buff_addr_fifo_data_o <= f_addr(r_base, r_stride, r_wr_idx);
                        r_wr_idx              <= f_next_idx(r_wr_idx);
                        r_preload_cnt         <= r_preload_cnt + 4'd1;
                        if (w_out_sat) err_o <= 1'b1;
                        else           r_outstanding <= r_outstanding + 4'd1;
                        if (r_preload_cnt == 4'(g_PRELOAD - 1)) r_state <= RUN;
                    end
                end

                RUN: begin
                    if (!enable_i) begin
                        r_state <= IDLE;
                    end else if (!frame_size_fifo_empty_i) begin
                        frame_size_fifo_rd_o <= 1'b1;
                        r_rd_phase           <= 1'b0;
                        r_state              <= RDWAIT;
                    end
                end

                RDWAIT: begin
                    // Frame size is valid only in the cycle after the read strobe.
                    if (!r_rd_phase) begin
                        r_rd_phase <= 1'b1;
                    end else begin
                        last_size_o   <= frame_size_i;
                        last_idx_o    <= r_cmp_idx;
                        last_addr_o   <= f_addr(r_base, r_stride, r_cmp_idx);
                        frame_done_o  <= 1'b1;
                        frame_count_o <= frame_count_o + 16'd1;
                        r_cmp_idx     <= f_next_idx(r_cmp_idx);
                        if (r_outstanding == 4'd0) err_o <= 1'b1;
                        else                       r_outstanding <= r_outstanding - 4'd1;
                        r_state <= enable_i ? PUSH : IDLE;
                    end
                end

                PUSH: begin
                    if (!enable_i) begin
                        r_state <= IDLE;
                    end else if (!buff_addr_fifo_full_i) begin
                        buff_addr_fifo_wr_o   <= 1'b1;
                        buff_addr_fifo_data_o <= f_addr(r_base, r_stride, w_push_idx);
                        r_wr_idx              <= f_next_idx(w_push_idx);
                        if (w_out_sat) err_o <= 1'b1;
                        else           r_outstanding <= r_outstanding + 4'd1;
                        r_state <= RUN;
                    end
                end

                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vdma_buff_scheduler.sv
// Self-checking bench for vdma_buff_scheduler: table of frame completions with a
// write-address scoreboard, plus hand-written full-stall, error and reset sequences.
module tb_vdma_buff_scheduler;

    localparam logic [31:0] BASE   = 32'h1000_0000;
    localparam logic [31:0] STRIDE = 32'h0020_0000;

    logic        aclk_i = 1'b0;
    logic        aclk_rstn_i = 1'b0;
    logic        enable_i = 1'b0;
    logic [31:0] base_addr_i = '0;
    logic [31:0] stride_i = '0;
    logic        hold_valid_i = 1'b0;
    logic [2:0]  hold_idx_i = '0;
    logic        buff_addr_fifo_full_i = 1'b0;
    logic        buff_addr_fifo_wr_o;
    logic [31:0] buff_addr_fifo_data_o;
    logic        frame_size_fifo_empty_i = 1'b1;
    logic        frame_size_fifo_rd_o;
    logic [31:0] frame_size_i = '0;
    logic        frame_done_o;
    logic [31:0] last_addr_o;
    logic [31:0] last_size_o;
    logic [2:0]  last_idx_o;
    logic [15:0] frame_count_o;
    logic        err_o;

    vdma_buff_scheduler dut (
        .aclk_i                  (aclk_i),
        .aclk_rstn_i             (aclk_rstn_i),
        .enable_i                (enable_i),
        .base_addr_i             (base_addr_i),
        .stride_i                (stride_i),
        .hold_valid_i            (hold_valid_i),
        .hold_idx_i              (hold_idx_i),
        .buff_addr_fifo_full_i   (buff_addr_fifo_full_i),
        .buff_addr_fifo_wr_o     (buff_addr_fifo_wr_o),
        .buff_addr_fifo_data_o   (buff_addr_fifo_data_o),
        .frame_size_fifo_empty_i (frame_size_fifo_empty_i),
        .frame_size_fifo_rd_o    (frame_size_fifo_rd_o),
        .frame_size_i            (frame_size_i),
        .frame_done_o            (frame_done_o),
        .last_addr_o             (last_addr_o),
        .last_size_o             (last_size_o),
        .last_idx_o              (last_idx_o),
        .frame_count_o           (frame_count_o),
        .err_o                   (err_o)
    );

    always #5 aclk_i = ~aclk_i;

    typedef struct {
        logic        restart;
        logic        hold_v;
        logic [2:0]  hold_idx;
        logic [31:0] size;
        logic [31:0] exp_push;
        logic [31:0] exp_last_addr;
        logic [2:0]  exp_last_idx;
        logic [15:0] exp_count;
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] size;
        logic [2:0]  idx;
        logic [15:0] cnt;
    } cap_t;

    vec_t        vecs[8];
    logic [31:0] exp_q[$];
    logic [31:0] obs_q[$];
    logic [31:0] size_q[$];
    cap_t        cap_q[$];
    int          checks = 0;
    int          errors = 0;
    int          rd_cnt = 0;
    int          viol = 0;
    logic        full_smp = 1'b0;

    function automatic logic [31:0] addr_of(input int i);
        return BASE + STRIDE * 32'(i);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge aclk_i);
        #1;
    endtask

    // Frame-size FIFO model: pops on the read strobe, data valid the following cycle.
    always @(negedge aclk_i) begin
        if (frame_size_fifo_rd_o && size_q.size() > 0) frame_size_i = size_q.pop_front();
        frame_size_fifo_empty_i = (size_q.size() == 0);
    end

    always @(posedge aclk_i) full_smp = buff_addr_fifo_full_i;

    // Output monitor: records writes and completions, counts reads and protocol violations.
    always @(negedge aclk_i) begin
        if (buff_addr_fifo_wr_o) begin
            obs_q.push_back(buff_addr_fifo_data_o);
            if (full_smp || frame_size_fifo_rd_o) viol++;
        end
        if (frame_size_fifo_rd_o) rd_cnt++;
        if (frame_done_o) cap_q.push_back('{last_addr_o, last_size_o, last_idx_o, frame_count_o});
    end

    task automatic drain(input string name);
        for (int k = 0; k < 40 && obs_q.size() < exp_q.size(); k++) tick(1);
        check({name, " write count"}, 32'(obs_q.size()), 32'(exp_q.size()));
        while (exp_q.size() > 0 && obs_q.size() > 0) check({name, " addr"}, obs_q.pop_front(), exp_q.pop_front());
        exp_q.delete();
        tick(3);
        check({name, " extra writes"}, 32'(obs_q.size()), 32'd0);
        obs_q.delete();
    endtask

    task automatic wait_done(input string name, output cap_t c);
        for (int k = 0; k < 40 && cap_q.size() == 0; k++) tick(1);
        check({name, " done seen"}, 32'(cap_q.size()), 32'd1);
        c = '{32'd0, 32'd0, 3'd0, 16'd0};
        if (cap_q.size() > 0) c = cap_q.pop_front();
    endtask

    task automatic restart_prime(input string name);
        enable_i = 1'b0;
        tick(2);
        enable_i = 1'b1;
        exp_q.push_back(addr_of(0));
        exp_q.push_back(addr_of(1));
        drain(name);
    endtask

    initial begin
        cap_t c;
        int   rd0;

        vecs[0] = '{1'b0, 1'b0, 3'd0, 32'h0007_E900, 32'h1040_0000, 32'h1000_0000, 3'd0, 16'd1};
        vecs[1] = '{1'b0, 1'b0, 3'd0, 32'h0000_0000, 32'h1060_0000, 32'h1020_0000, 3'd1, 16'd2};
        vecs[2] = '{1'b0, 1'b0, 3'd0, 32'hFFFF_FFFF, 32'h1000_0000, 32'h1040_0000, 3'd2, 16'd3};
        vecs[3] = '{1'b0, 1'b0, 3'd0, 32'h0001_2345, 32'h1020_0000, 32'h1060_0000, 3'd3, 16'd4};
        vecs[4] = '{1'b0, 1'b0, 3'd0, 32'hA5A5_5A5A, 32'h1040_0000, 32'h1000_0000, 3'd0, 16'd5};
        vecs[5] = '{1'b0, 1'b0, 3'd0, 32'h0000_0001, 32'h1060_0000, 32'h1020_0000, 3'd1, 16'd6};
        vecs[6] = '{1'b1, 1'b1, 3'd2, 32'h0007_E900, 32'h1060_0000, 32'h1000_0000, 3'd0, 16'd7};
        vecs[7] = '{1'b0, 1'b0, 3'd0, 32'h8000_0000, 32'h1000_0000, 32'h1020_0000, 3'd1, 16'd8};

        tick(3);
        check("reset wr", 32'(buff_addr_fifo_wr_o), 32'd0);
        check("reset data", buff_addr_fifo_data_o, 32'd0);
        check("reset rd", 32'(frame_size_fifo_rd_o), 32'd0);
        check("reset count", 32'(frame_count_o), 32'd0);
        check("reset err", 32'(err_o), 32'd0);
        aclk_rstn_i = 1'b1;
        tick(2);

        base_addr_i = BASE;
        stride_i    = STRIDE;
        enable_i    = 1'b1;
        exp_q.push_back(32'h1000_0000);
        exp_q.push_back(32'h1020_0000);
        drain("prime");

        for (int i = 0; i < 8; i++) begin
            if (vecs[i].restart) restart_prime("reprime");
            hold_valid_i = vecs[i].hold_v;
            hold_idx_i   = vecs[i].hold_idx;
            rd0 = rd_cnt;
            exp_q.push_back(vecs[i].exp_push);
            size_q.push_back(vecs[i].size);
            wait_done($sformatf("vec%0d", i), c);
            drain($sformatf("vec%0d push", i));
            check($sformatf("vec%0d last_addr", i), c.addr, vecs[i].exp_last_addr);
            check($sformatf("vec%0d last_size", i), c.size, vecs[i].size);
            check($sformatf("vec%0d last_idx", i), 32'(c.idx), 32'(vecs[i].exp_last_idx));
            check($sformatf("vec%0d count", i), 32'(c.cnt), 32'(vecs[i].exp_count));
            check($sformatf("vec%0d rd pulses", i), 32'(rd_cnt - rd0), 32'd1);
            check($sformatf("vec%0d done pulses", i), 32'(cap_q.size()), 32'd0);
        end
        hold_valid_i = 1'b0;

        // Address FIFO full throughout PUSH: no write until it drains, then exactly one.
        buff_addr_fifo_full_i = 1'b1;
        rd0 = rd_cnt;
        size_q.push_back(32'h0000_4000);
        wait_done("full", c);
        tick(10);
        check("full no wr", 32'(obs_q.size()), 32'd0);
        exp_q.push_back(32'h1020_0000);
        buff_addr_fifo_full_i = 1'b0;
        drain("full release");
        check("full last_idx", 32'(c.idx), 32'd2);
        check("full last_addr", c.addr, 32'h1040_0000);
        check("full count", 32'(c.cnt), 32'd9);
        check("full rd pulses", 32'(rd_cnt - rd0), 32'd1);

        // Completion with nothing outstanding: sticky error until the next IDLE->PRIME.
        check("err before", 32'(err_o), 32'd0);
        force dut.r_outstanding = 4'd0;
        size_q.push_back(32'h1234_5678);
        wait_done("err", c);
        release dut.r_outstanding;
        exp_q.push_back(32'h1040_0000);
        drain("err push");
        check("err last_idx", 32'(c.idx), 32'd3);
        check("err count", 32'(c.cnt), 32'd10);
        check("err set", 32'(err_o), 32'd1);
        enable_i = 1'b0;
        tick(3);
        check("err sticky idle", 32'(err_o), 32'd1);
        enable_i = 1'b1;
        exp_q.push_back(addr_of(0));
        exp_q.push_back(addr_of(1));
        drain("err reprime");
        check("err cleared", 32'(err_o), 32'd0);

        // Reset while the first PRIME write is on the bus.
        enable_i = 1'b0;
        tick(2);
        enable_i = 1'b1;
        tick(2);
        check("prime wr before reset", 32'(buff_addr_fifo_wr_o), 32'd1);
        #1 aclk_rstn_i = 1'b0;
        #1;
        check("async rst wr", 32'(buff_addr_fifo_wr_o), 32'd0);
        check("async rst data", buff_addr_fifo_data_o, 32'd0);
        check("async rst count", 32'(frame_count_o), 32'd0);
        check("async rst last_addr", last_addr_o, 32'd0);
        check("async rst last_size", last_size_o, 32'd0);
        check("async rst last_idx", 32'(last_idx_o), 32'd0);
        check("async rst done", 32'(frame_done_o), 32'd0);
        check("async rst err", 32'(err_o), 32'd0);
        enable_i = 1'b0;
        tick(3);
        check("writes during reset", 32'(obs_q.size()), 32'd0);
        check("protocol violations", 32'(viol), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vdma_buff_scheduler.md
VDMA_BUFF_SCHEDULER -- requirements
Module: vdma_buff_scheduler

Interface
REQ-001 SHALL have parameter g_NUM_BUFF, default 4, number of frame buffers in the ring (legal 2..8).
REQ-002 SHALL have parameter g_PRELOAD, default 2, addresses pushed before the first frame completes (legal 1..g_NUM_BUFF-1).
REQ-003 SHALL have one clock and an asynchronous active-low reset, ports: aclk_i in 1 (clock); aclk_rstn_i in 1 (reset).
REQ-004 SHALL have port enable_i, in, 1: scheduler enable, level.
REQ-005 SHALL have port base_addr_i, in, 32: buffer 0 address, sampled on entry to PRIME.
REQ-006 SHALL have port stride_i, in, 32: buffer spacing in bytes, sampled on entry to PRIME.
REQ-007 SHALL have ports hold_valid_i, in, 1, and hold_idx_i, in, 3: buffer currently locked by the reader.
REQ-008 SHALL have ports buff_addr_fifo_full_i, in, 1; buff_addr_fifo_wr_o, out, 1; buff_addr_fifo_data_o, out, 32.
REQ-009 SHALL have ports frame_size_fifo_empty_i, in, 1; frame_size_fifo_rd_o, out, 1; frame_size_i, in, 32 (valid the cycle after rd).
REQ-010 SHALL have outputs frame_done_o (1, pulse), last_addr_o (32), last_size_o (32), last_idx_o (3), frame_count_o (16), err_o (1, sticky).

Function
REQ-011 SHALL implement states IDLE, PRIME, RUN, RDWAIT, PUSH.
REQ-012 addr(i) SHALL equal base + i*stride, truncated to 32 bits, with base and stride from the registered copies.
REQ-013 IDLE: when enable_i=1, go to PRIME; clear wr_idx, cmp_idx and outstanding; latch base and stride.
REQ-014 PRIME: each cycle with full=0, assert wr=1 with data=addr(wr_idx), advance wr_idx, and increment outstanding.
REQ-015 PRIME: after g_PRELOAD pushes, go to RUN; with full=1, wr=0 and PRIME holds.
REQ-016 RUN: when empty=0, assert frame_size_fifo_rd_o for exactly one cycle and go to RDWAIT.
REQ-017 RDWAIT: capture last_size_o=frame_size_i, last_idx_o=cmp_idx, last_addr_o=addr(cmp_idx).
REQ-018 RDWAIT also: pulse frame_done_o for one cycle, increment frame_count_o (wraps 0xFFFF->0), advance cmp_idx, decrement outstanding, then go to PUSH.
REQ-019 RDWAIT with outstanding=0: set err_o, do not decrement, and still report the completion.
REQ-020 PUSH: when hold_valid_i=1 and hold_idx_i=wr_idx, skip that index (wr_idx+1) before pushing; at most one skip per push.
REQ-021 PUSH: push addr(wr_idx) when full=0, advance wr_idx, increment outstanding, and return to RUN; with full=1, wait.
REQ-022 Index arithmetic SHALL wrap modulo g_NUM_BUFF (g_NUM_BUFF-1 -> 0).
REQ-023 wr and rd SHALL be registered outputs, never asserted in the same cycle, and wr SHALL never be asserted while full=1 was sampled.
REQ-024 enable_i=0 in PRIME, RUN or PUSH SHALL go to IDLE next cycle, dropping the pending push.
REQ-025 enable_i=0 in RDWAIT SHALL complete the capture, then go to IDLE.
REQ-026 Outstanding above g_NUM_BUFF SHALL never occur; saturate and set err_o.
REQ-027 err_o SHALL clear only on reset or on an IDLE->PRIME transition.

Reset
REQ-028 On aclk_rstn_i=0, SHALL go to IDLE with all outputs, indices and counters at 0, independent of the clock.
REQ-029 Reset mid-push SHALL drop the write immediately (wr=0 in the same cycle reset asserts).

Verification
REQ-030 Bench SHALL cover: base=0x1000_0000, stride=0x0020_0000, enable -> two writes, 0x1000_0000 then 0x1020_0000, then RUN.
REQ-031 Bench SHALL cover: frame size 0x0007_E900 queued -> rd one cycle, then frame_done_o, last_addr_o=0x1000_0000, last_size_o=0x0007_E900, and push of 0x1040_0000.
REQ-032 Bench SHALL cover: six completions -> pushed indices 2,3,0,1,2,3 (wrap) and frame_count_o=6.
REQ-033 Bench SHALL cover: hold_valid=1, hold_idx=2 at the first push -> index 3 (0x1060_0000) pushed and index 2 skipped.
REQ-034 Bench SHALL cover: full held high for 10 cycles in PUSH -> no wr during those cycles, and exactly one write after full drops.
REQ-035 Bench SHALL cover: frame sizes with outstanding=0 (forced) -> err_o=1 until re-enable; and reset in PRIME -> all outputs 0 without a clock edge.
